// File: rtl/instruction_fetch_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_if
//   Bundles the two handshakes that the fetch unit sits between:
//     - memory read port  : mem_req / mem_addr  ->  mem_ack / mem_rdata
//     - decoder offer     : ir_out / ir_valid   ->  ir_ready
//   Modports:
//     master : the fetch unit (drives req/addr and the instruction offer)
//     slave  : the environment (memory answers, decoder accepts)
// ----------------------------------------------------------------------------
interface instruction_fetch_if #(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 8
);
  logic              mem_req;
  logic [WIDTH-1:0]  mem_addr;
  logic              mem_ack;
  logic [IWIDTH-1:0] mem_rdata;
  logic [IWIDTH-1:0] ir_out;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output ir_out,
    output ir_valid,
    input  ir_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  ir_out,
    input  ir_valid,
    output ir_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//   Reader side of the program counter. Takes the current PC, issues a memory
//   read with a req/ack handshake, latches the returned word into the
//   instruction register and offers it to the decoder with valid/ready.
//   pc_inc pulses once per successfully fetched word.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     run        fetch enable (level); only gates starting a new request
//     flush      synchronous discard of in-flight and held instruction
//     pc_in      current PC from program_counter
//     pc_inc     one-cycle pulse, drives program_counter enable
//     fetch_err  sticky timeout flag (constant 0 unless FETCH_TIMEOUT_EN)
//     bus        instruction_fetch_if.master: mem_req/mem_addr/mem_ack/
//                mem_rdata and ir_out/ir_valid/ir_ready
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     When defined, a request that sees no mem_ack for TIMEOUT_CYCLES cycles
//     is abandoned and fetch_err is set until flush or reset. When undefined,
//     REQ waits for mem_ack indefinitely.
// ----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int WIDTH          = 8,
  parameter int IWIDTH         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                flush,
  input  logic [WIDTH-1:0]    pc_in,
  output logic                pc_inc,
  output logic                fetch_err,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              discard_r;
  logic              discard_s;
  logic              load_s;
  logic              timeout_s;
  logic              err_block_s;
  logic              mem_req_r;
  logic              ir_valid_r;
  logic              pc_inc_r;
  logic [IWIDTH-1:0] ir_out_r;

  // The address is a straight copy of the PC. It is stable during REQ because
  // pc_inc is never high while a request is outstanding.
  assign bus.mem_addr = pc_in;
  assign bus.mem_req  = mem_req_r;
  assign bus.ir_out   = ir_out_r;
  assign bus.ir_valid = ir_valid_r;
  assign pc_inc       = pc_inc_r;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tcnt_r;
  logic          fetch_err_r;

  // The count holds the number of ack-less REQ cycles already completed, so
  // the cycle that would bring it to TIMEOUT_CYCLES is the abort cycle.
  assign timeout_s   = (state_r == REQ) && !bus.mem_ack &&
                       (tcnt_r == CW'(TIMEOUT_CYCLES - 1));
  assign err_block_s = fetch_err_r;
  assign fetch_err   = fetch_err_r;

  // Wait counter: cleared on REQ entry, +1 per REQ cycle without ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_r <= {CW{1'b0}};
    end else if ((state_s == REQ) && (state_r != REQ)) begin
      tcnt_r <= {CW{1'b0}};
    end else if ((state_r == REQ) && !bus.mem_ack) begin
      tcnt_r <= tcnt_r + CW'(1);
    end else begin
      tcnt_r <= tcnt_r;
    end
  end

  // Sticky error flag; flush clears it and takes priority over a new timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err_r <= 1'b0;
    end else if (flush) begin
      fetch_err_r <= 1'b0;
    end else if (timeout_s) begin
      fetch_err_r <= 1'b1;
    end else begin
      fetch_err_r <= fetch_err_r;
    end
  end
`else
  assign timeout_s   = 1'b0;
  assign err_block_s = 1'b0;
  // Constant 0; the timeout parameter has no effect in this build.
  assign fetch_err   = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

  // Next-state logic and per-cycle decisions of the fetch FSM.
  always_comb begin
    state_s   = state_r;
    discard_s = discard_r;
    load_s    = 1'b0;
    case (state_r)
      IDLE: begin
        discard_s = 1'b0;
        if (run && !flush && !err_block_s) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          // A flush seen earlier (discard) or right now drops the word.
          if (discard_r || flush) begin
            state_s   = IDLE;
            discard_s = 1'b0;
          end else begin
            state_s = HOLD;
            load_s  = 1'b1;
          end
        end else if (timeout_s) begin
          state_s   = IDLE;
          discard_s = 1'b0;
        end else if (flush) begin
          // The request is never withdrawn; remember to drop its data.
          state_s   = REQ;
          discard_s = 1'b1;
        end else begin
          state_s = REQ;
        end
      end
      HOLD: begin
        if (flush) begin
          state_s = IDLE;
        end else if (bus.ir_ready) begin
          if (run) begin
            state_s = REQ;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s   = IDLE;
        discard_s = 1'b0;
      end
    endcase
  end

  // FSM state and discard flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      discard_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      discard_r <= discard_s;
    end
  end

  // Registered handshake outputs, decoded from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_r  <= 1'b0;
      ir_valid_r <= 1'b0;
      pc_inc_r   <= 1'b0;
    end else begin
      mem_req_r  <= (state_s == REQ);
      ir_valid_r <= (state_s == HOLD);
      pc_inc_r   <= load_s;
    end
  end

  // Instruction register: loaded only by an accepted, non-discarded ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_out_r <= {IWIDTH{1'b0}};
    end else if (load_s) begin
      ir_out_r <= bus.mem_rdata;
    end else begin
      ir_out_r <= ir_out_r;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  logic       clk;
  logic       rst_n;
  logic       run;
  logic       flush;
  logic [7:0] pc;
  logic       pc_inc;
  logic       fetch_err;
  int         checks;
  int         errors;
  int         pcinc_cnt;
  int         base;
  int         wcnt;
  int         ack_delay;
  bit         ack_en;
  logic [7:0] exp_ir [4];

  instruction_fetch_if #(.WIDTH(8), .IWIDTH(8)) bus ();

  instruction_fetch #(.WIDTH(8), .IWIDTH(8), .TIMEOUT_CYCLES(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .flush     (flush),
    .pc_in     (pc),
    .pc_inc    (pc_inc),
    .fetch_err (fetch_err),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model: advances on pc_inc.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 8'h00;
    else if (pc_inc) pc <= pc + 8'h01;
  end

  always @(posedge clk) begin
    if (pc_inc) pcinc_cnt <= pcinc_cnt + 1;
  end

  // Memory model: acks after ack_delay request cycles; data = addr ^ 0xA5.
  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always_comb begin
    bus.mem_ack   = bus.mem_req && ack_en && (wcnt >= ack_delay);
    bus.mem_rdata = bus.mem_addr ^ 8'hA5;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; errors = 0; pcinc_cnt = 0; wcnt = 0;
    exp_ir[0] = 8'hA5; exp_ir[1] = 8'hA4; exp_ir[2] = 8'hA7; exp_ir[3] = 8'hA6;
    rst_n = 1'b0; run = 1'b0; flush = 1'b0; bus.ir_ready = 1'b0;
    ack_en = 1'b1; ack_delay = 0;

    // 1. Reset
    tick(2);
    chk("rst_mem_req", 16'(bus.mem_req), 16'd0);
    chk("rst_ir_valid", 16'(bus.ir_valid), 16'd0);
    chk("rst_pc_inc", 16'(pc_inc), 16'd0);
    chk("rst_ir_out", 16'(bus.ir_out), 16'h00);
    chk("rst_fetch_err", 16'(fetch_err), 16'd0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_run0", 16'(bus.mem_req), 16'd0);
    ack_en = 1'b0; run = 1'b1;
    tick(1);
    chk("run_to_req", 16'(bus.mem_req), 16'd1);
    tick(2);
    chk("req_held", 16'(bus.mem_req), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 16'(bus.mem_req), 16'd0);
    chk("async_rst_valid", 16'(bus.ir_valid), 16'd0);
    run = 1'b0;
    tick(1);
    rst_n = 1'b1; ack_en = 1'b1;
    tick(1);
    chk("post_rst_idle", 16'(bus.mem_req), 16'd0);

    // 2. Zero-wait stream
    base = pcinc_cnt; bus.ir_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("zw_addr", 16'(bus.mem_addr), 16'(i));
      chk("zw_req", 16'(bus.mem_req), 16'd1);
      tick(1);
      chk("zw_ir_out", 16'(bus.ir_out), 16'(exp_ir[i]));
      chk("zw_valid", 16'(bus.ir_valid), 16'd1);
      chk("zw_pc_inc", 16'(pc_inc), 16'd1);
      if (i == 3) run = 1'b0;
    end
    tick(1);
    chk("zw_pc", 16'(pc), 16'h04);
    chk("zw_pcinc_cnt", 16'(pcinc_cnt - base), 16'd4);
    chk("zw_idle", 16'(bus.mem_req), 16'd0);

    // 3. Wait states + backpressure
    base = pcinc_cnt; ack_delay = 3; bus.ir_ready = 1'b0; run = 1'b1;
    tick(1);
    chk("ws_req", 16'(bus.mem_req), 16'd1);
    chk("ws_noack", 16'(bus.mem_ack), 16'd0);
    tick(3);
    chk("ws_ack", 16'(bus.mem_ack), 16'd1);
    tick(1);
    chk("ws_ir_out", 16'(bus.ir_out), 16'hA1);
    chk("ws_pc_inc", 16'(pc_inc), 16'd1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("bp_ir_out", 16'(bus.ir_out), 16'hA1);
      chk("bp_valid", 16'(bus.ir_valid), 16'd1);
      chk("bp_no_req", 16'(bus.mem_req), 16'd0);
      chk("bp_no_inc", 16'(pc_inc), 16'd0);
    end
    chk("bp_pc", 16'(pc), 16'h05);
    bus.ir_ready = 1'b1;
    tick(1);
    chk("bp_accept_valid", 16'(bus.ir_valid), 16'd0);
    chk("bp_next_addr", 16'(bus.mem_addr), 16'h05);
    tick(3);
    chk("ws2_ack", 16'(bus.mem_ack), 16'd1);
    run = 1'b0;
    tick(1);
    chk("ws2_ir_out", 16'(bus.ir_out), 16'hA0);
    tick(1);
    chk("ws_pcinc_cnt", 16'(pcinc_cnt - base), 16'd2);
    chk("ws_pc", 16'(pc), 16'h06);

    // 4a. Flush one cycle before a delayed ack
    base = pcinc_cnt; run = 1'b1;
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0; run = 1'b0;
    chk("fl1_req_kept", 16'(bus.mem_req), 16'd1);
    chk("fl1_ack", 16'(bus.mem_ack), 16'd1);
    tick(1);
    chk("fl1_valid", 16'(bus.ir_valid), 16'd0);
    chk("fl1_pc_inc", 16'(pc_inc), 16'd0);
    chk("fl1_idle", 16'(bus.mem_req), 16'd0);
    tick(1);
    chk("fl1_pc", 16'(pc), 16'h06);

    // 4b. Flush on the ack cycle
    run = 1'b1;
    tick(4);
    chk("fl2_ack", 16'(bus.mem_ack), 16'd1);
    flush = 1'b1; run = 1'b0;
    tick(1);
    flush = 1'b0;
    chk("fl2_valid", 16'(bus.ir_valid), 16'd0);
    chk("fl2_pc_inc", 16'(pc_inc), 16'd0);
    chk("fl2_idle", 16'(bus.mem_req), 16'd0);
    tick(1);
    chk("fl2_pc", 16'(pc), 16'h06);
    chk("fl_pcinc_cnt", 16'(pcinc_cnt - base), 16'd0);

    // 5. Flush in HOLD
    ack_delay = 0; bus.ir_ready = 1'b0; run = 1'b1;
    tick(1);
    chk("fh_addr", 16'(bus.mem_addr), 16'h06);
    tick(1);
    chk("fh_ir_out", 16'(bus.ir_out), 16'hA3);
    run = 1'b0;
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("fh_valid", 16'(bus.ir_valid), 16'd0);
    chk("fh_pc", 16'(pc), 16'h07);
    run = 1'b1; bus.ir_ready = 1'b1;
    tick(1);
    chk("fh_refetch_addr", 16'(bus.mem_addr), 16'h07);
    tick(1);
    chk("fh_refetch_ir", 16'(bus.ir_out), 16'hA2);
    run = 1'b0;
    tick(1);

`ifdef FETCH_TIMEOUT_EN
    // 6. Timeout
    ack_en = 1'b0; run = 1'b1;
    tick(15);
    chk("to_req_15", 16'(bus.mem_req), 16'd1);
    chk("to_no_err_yet", 16'(fetch_err), 16'd0);
    tick(1);
    chk("to_req_drop", 16'(bus.mem_req), 16'd0);
    chk("to_err", 16'(fetch_err), 16'd1);
    tick(3);
    chk("to_blocked", 16'(bus.mem_req), 16'd0);
    chk("to_err_sticky", 16'(fetch_err), 16'd1);
    ack_en = 1'b1; flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("to_err_clr", 16'(fetch_err), 16'd0);
    tick(1);
    chk("to_resume", 16'(bus.mem_req), 16'd1);
    chk("to_resume_addr", 16'(bus.mem_addr), 16'h08);
    run = 1'b0;
    tick(1);
    chk("to_resume_ir", 16'(bus.ir_out), 16'hAD);
    tick(1);
`else
    // 6. Without timeout: REQ waits indefinitely
    ack_en = 1'b0; run = 1'b1;
    tick(20);
    chk("nt_req_wait", 16'(bus.mem_req), 16'd1);
    chk("nt_err_zero", 16'(fetch_err), 16'd0);
    ack_en = 1'b1; run = 1'b0;
    tick(1);
    chk("nt_ir_out", 16'(bus.ir_out), 16'hAD);
    chk("nt_pc_inc", 16'(pc_inc), 16'd1);
    tick(1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
